// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler
//   Shares one external combinational ALU between NREQ requesters. A round-robin
//   arbiter picks one request at a time; the operands are registered onto the
//   alu_* ports, the ALU result is captured one cycle later and held on
//   rsp_data_o until the owning requester takes it. One operation in flight.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous reset, active-high
//   req_valid_i    [NREQ]     request pending per requester
//   req_ready_o    [NREQ]     one-hot accept (combinational)
//   req_a_i        [NREQ*W]   operand A, slice i = [i*W +: W]
//   req_b_i        [NREQ*W]   operand B, same packing
//   req_s_i        [NREQ*3]   op select, slice i = [i*3 +: 3]
//   rsp_valid_o    [NREQ]     one-hot: result for requester i on rsp_data_o
//   rsp_ready_i    [NREQ]     requester i takes the result
//   rsp_data_o     [W]        registered result
//   alu_a_o/b_o    [W]        registered operands to the ALU
//   alu_s_o        [3]        registered op select to the ALU
//   alu_result_i   [W]        ALU output
//   busy_o                    high whenever the FSM is not idle
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrate; accept the round-robin winner and latch its operands
// EXEC  | ALU is evaluating the latched operands; capture the result
// RESP  | hold rsp_valid/rsp_data until the owner asserts rsp_ready

module alu_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*W-1:0] req_a_i,
    input  logic [NREQ*W-1:0] req_b_i,
    input  logic [NREQ*3-1:0] req_s_i,
    output logic [NREQ-1:0]   rsp_valid_o,
    input  logic [NREQ-1:0]   rsp_ready_i,
    output logic [W-1:0]      rsp_data_o,
    output logic [W-1:0]      alu_a_o,
    output logic [W-1:0]      alu_b_o,
    output logic [2:0]        alu_s_o,
    input  logic [W-1:0]      alu_result_i,
    output logic              busy_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;
    logic [W-1:0]    alu_a_q, alu_a_d;
    logic [W-1:0]    alu_b_q, alu_b_d;
    logic [2:0]      alu_s_q, alu_s_d;
    logic [NREQ-1:0] grant;
    logic            found;
    logic [PW-1:0]   winner;

    // (base + off) mod NREQ, for NREQ that need not be a power of two.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return sum[PW-1:0];
    endfunction

    // Round-robin search starting at ptr_q; first valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid_i[wrap_add(ptr_q, k)]) begin
                found  = 1'b1;
                winner = wrap_add(ptr_q, k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_s_d     = alu_s_q;
        grant       = '0;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant[winner] = 1'b1;
                    alu_a_d       = req_a_i[winner*W +: W];
                    alu_b_d       = req_b_i[winner*W +: W];
                    alu_s_d       = req_s_i[winner*3 +: 3];
                    owner_d       = winner;
                    state_d       = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d           = alu_result_i;
                rsp_valid_d          = '0;
                rsp_valid_d[owner_q] = 1'b1;
                state_d              = RESP;
            end
            RESP: begin
                if (rsp_ready_i[owner_q]) begin
                    rsp_valid_d = '0;
                    ptr_d       = wrap_add(owner_q, 1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_s_q     <= alu_s_d;
        end
    end

    // The accept must not fire in a reset cycle, since that edge discards it.
    assign req_ready_o = rst_i ? '0 : grant;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_s_o     = alu_s_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
module tb_alu_rr_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*3-1:0] req_s;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_data;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [2:0]        alu_s;
    logic [W-1:0]      alu_result;
    logic              busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.NREQ(NREQ), .W(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_s_i      (req_s),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_s_o      (alu_s),
        .alu_result_i (alu_result),
        .busy_o       (busy)
    );

    // External ALU
    always_comb begin
        alu_result = '0;
        case (alu_s)
            3'b000: alu_result = ~alu_a;
            3'b001: alu_result = alu_a & alu_b;
            3'b010: alu_result = alu_a ^ alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = alu_a - 32'd1;
            3'b101: alu_result = alu_a + alu_b;
            3'b110: alu_result = alu_a - alu_b;
            3'b111: alu_result = alu_a + 32'd1;
            default: alu_result = '0;
        endcase
    end

    task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] s);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_s[i*3 +: 3] = s;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        rsp_ready = '0;
        req_valid = 4'b0001;
        set_slot(0, 32'd5, 32'd3, 3'b101);
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid);
        else pass_cnt++;
        total_cnt++;
        if (rsp_data !== 32'd0) $display("FAIL reset_rsp_data: got %h expected 0", rsp_data);
        else pass_cnt++;
        total_cnt++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_s !== 3'd0)
            $display("FAIL reset_alu_regs: got a=%h b=%h s=%b expected zeros", alu_a, alu_b, alu_s);
        else pass_cnt++;
    endtask

    task automatic test_single();
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0001) $display("FAIL single_accept: got %b expected 0001", req_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        req_valid = '0;
        total_cnt++;
        if (busy !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd3 || alu_s !== 3'b101)
            $display("FAIL single_latch: got busy=%b a=%h b=%h s=%b expected 1/5/3/101",
                     busy, alu_a, alu_b, alu_s);
        else pass_cnt++;
        total_cnt++;
        if (rsp_valid !== 4'b0000) $display("FAIL single_exec_rsp: got %b expected 0000", rsp_valid);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 32'd8)
            $display("FAIL single_result: got valid=%b data=%h expected 0001/8", rsp_valid, rsp_data);
        else pass_cnt++;
        rsp_ready = 4'b0001;
        @(posedge clk);
        #1;
        total_cnt++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0)
            $display("FAIL single_release: got valid=%b busy=%b expected 0000/0", rsp_valid, busy);
        else pass_cnt++;
    endtask

    task automatic test_alu_ops();
        logic [2:0]  ts [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
        logic [31:0] ta [8] = '{32'h0F0F0000, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
                                32'h00000000, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF};
        logic [31:0] tb [8] = '{32'h00000000, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0,
                                32'h00000000, 32'h00000002, 32'h00000005, 32'h00000000};
        logic [31:0] te [8] = '{32'hF0F0FFFF, 32'h0F000F00, 32'hF0F0F0F0, 32'hFFF0FFF0,
                                32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 32'h00000000};
        int n;
        rsp_ready = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            set_slot(0, ta[k], tb[k], ts[k]);
            req_valid = 4'b0001;
            #1;
            total_cnt++;
            if (req_ready !== 4'b0001) $display("FAIL alu_accept[%0d]: got %b expected 0001", k, req_ready);
            else pass_cnt++;
            @(posedge clk);
            #1;
            // Scramble the inputs after acceptance; the result must not move.
            req_valid = '0;
            set_slot(0, ~ta[k], 32'h12345678, ~ts[k]);
            n = 0;
            while (rsp_valid === 4'b0000 && n < 8) begin
                @(posedge clk);
                #1;
                n++;
            end
            total_cnt++;
            if (rsp_valid !== 4'b0001 || rsp_data !== te[k])
                $display("FAIL alu_op[%0d] s=%b: got valid=%b data=%h expected 0001/%h",
                         k, ts[k], rsp_valid, rsp_data, te[k]);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  grants [5];
        int          gcyc   [5];
        logic [31:0] rdat   [5];
        logic [3:0]  rown   [5];
        logic [3:0]  exp_g;
        int ng;
        int nr;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_slot(i, 32'(i * 16 + 1), 32'(i), 3'b101);
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        ng = 0;
        nr = 0;
        for (int cyc = 0; cyc < 40 && ng < 5; cyc++) begin
            #1;
            if (req_ready !== 4'b0000) begin
                grants[ng] = req_ready;
                gcyc[ng]   = cyc;
                ng++;
            end
            if (rsp_valid !== 4'b0000 && nr < 5) begin
                rdat[nr] = rsp_data;
                rown[nr] = rsp_valid;
                nr++;
            end
            if (ng < 5) @(negedge clk);
        end
        total_cnt++;
        if (ng !== 5) $display("FAIL rr_grant_count: got %0d expected 5", ng);
        else pass_cnt++;
        for (int k = 0; k < ng; k++) begin
            exp_g = 4'b0001 << (k % 4);
            total_cnt++;
            if (grants[k] !== exp_g) $display("FAIL rr_order[%0d]: got %b expected %b", k, grants[k], exp_g);
            else pass_cnt++;
        end
        for (int k = 1; k < ng; k++) begin
            total_cnt++;
            if (gcyc[k] - gcyc[k-1] !== 3)
                $display("FAIL rr_spacing[%0d]: got %0d cycles expected 3", k, gcyc[k] - gcyc[k-1]);
            else pass_cnt++;
        end
        total_cnt++;
        if (nr !== 4) $display("FAIL rr_rsp_count: got %0d expected 4", nr);
        else pass_cnt++;
        for (int k = 0; k < nr; k++) begin
            exp_g = 4'b0001 << (k % 4);
            total_cnt++;
            if (rown[k] !== exp_g || rdat[k] !== 32'(17 * k + 1))
                $display("FAIL rr_rsp[%0d]: got valid=%b data=%h expected %b/%h",
                         k, rown[k], rdat[k], exp_g, 32'(17 * k + 1));
            else pass_cnt++;
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL rr_drain: got busy=%b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        rsp_ready = 4'b0000;
        @(negedge clk);
        set_slot(2, 32'd7, 32'd9, 3'b101);
        req_valid = 4'b0100;
        @(posedge clk);
        #1;
        req_valid = 4'b1111;
        rsp_ready = 4'b1011;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            total_cnt++;
            if (rsp_valid !== 4'b0100 || rsp_data !== 32'd16)
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h expected 0100/10", k, rsp_valid, rsp_data);
            else pass_cnt++;
            total_cnt++;
            if (busy !== 1'b1 || req_ready !== 4'b0000)
                $display("FAIL bp_busy[%0d]: got busy=%b req_ready=%b expected 1/0000", k, busy, req_ready);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        rsp_ready = 4'b0100;
        @(posedge clk);
        #1;
        total_cnt++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0)
            $display("FAIL bp_release: got valid=%b busy=%b expected 0000/0", rsp_valid, busy);
        else pass_cnt++;
    endtask

    task automatic test_ptr_wrap();
        rsp_ready = 4'b1111;
        @(negedge clk);
        set_slot(1, 32'd100, 32'd1, 3'b111);
        set_slot(3, 32'd200, 32'd1, 3'b100);
        req_valid = 4'b0010;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0010) $display("FAIL wrap_setup: got %b expected 0010", req_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'b1010;
        #1;
        total_cnt++;
        if (req_ready !== 4'b1000) $display("FAIL wrap_first: got %b expected 1000", req_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (rsp_valid !== 4'b1000 || rsp_data !== 32'd199)
            $display("FAIL wrap_rsp3: got valid=%b data=%h expected 1000/c7", rsp_valid, rsp_data);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (req_ready !== 4'b0010) $display("FAIL wrap_second: got %b expected 0010", req_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 32'd101)
            $display("FAIL wrap_rsp1: got valid=%b data=%h expected 0010/65", rsp_valid, rsp_data);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        rsp_ready = 4'b1111;
        set_slot(0, 32'h0000_0A00, 32'h0000_00B0, 3'b011);
        set_slot(2, 32'd1, 32'd1, 3'b101);
        req_valid = 4'b0100;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0100) $display("FAIL mid_accept: got %b expected 0100", req_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 4'b1101;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0000) $display("FAIL mid_rst_ready: got %b expected 0000", req_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0)
            $display("FAIL mid_dropped: got valid=%b busy=%b expected 0000/0", rsp_valid, busy);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0001) $display("FAIL mid_ptr_zero: got %b expected 0001", req_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        req_valid = '0;
        total_cnt++;
        if (rsp_valid !== 4'b0000 || alu_a !== 32'h0000_0A00)
            $display("FAIL mid_regrant: got valid=%b alu_a=%h expected 0000/a00", rsp_valid, alu_a);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 32'h0000_0AB0)
            $display("FAIL mid_result: got valid=%b data=%h expected 0001/ab0", rsp_valid, rsp_data);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        req_s     = '0;
        test_reset();
        test_single();
        test_alu_ops();
        test_back_to_back();
        test_backpressure();
        test_ptr_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

endmodule
